// File: rtl/wb_ram_arbiter_n_pkg.sv
// Shared types and helpers for the N-master Wishbone RAM arbiter.
// Holds the FSM state encoding and counter widths.
package wb_ram_arbiter_n_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // burst counter covers MAX_BURST up to 15
    typedef logic [3:0] bcnt_t;

    // watchdog counter
    typedef logic [7:0] wdog_t;

    // width of a master index, never below one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_ram_arbiter_n_picker.sv
// Combinational round-robin priority encoder.
// Scans last+1, last+2, ... (mod N) and reports the first requester.
module wb_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] pos;

    // rotate the search start to just past the previous winner
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 1; k <= N; k++) begin
            pos = {1'b0, last} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!any && req[pos[IW-1:0]]) begin
                any = 1'b1;
                idx = pos[IW-1:0];
                gnt[pos[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ram_arbiter_n.sv
// N-master Wishbone B4 classic arbiter in front of the shared user RAM.
// Define WB_ARB_TIMEOUT_EN to add the slave-ack watchdog.
module wb_ram_arbiter_n
    import wb_ram_arbiter_n_pkg::*;
#(
    parameter int N_MST     = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [N_MST-1:0]        m_stb_i,
    input  logic [N_MST-1:0]        m_cyc_i,
    input  logic [N_MST-1:0]        m_we_i,
    input  logic [N_MST*DW/8-1:0]   m_sel_i,
    input  logic [N_MST*DW-1:0]     m_dat_i,
    input  logic [N_MST*AW-1:0]     m_adr_i,
    output logic [N_MST-1:0]        m_ack_o,
    output logic [N_MST-1:0]        m_err_o,
    output logic [DW-1:0]           m_dat_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    output logic                    s_we_o,
    output logic [DW/8-1:0]         s_sel_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [AW-1:0]           s_adr_o,
    input  logic                    s_ack_i,
    input  logic [DW-1:0]           s_dat_i,
    output logic [N_MST-1:0]        gnt_o
);

    localparam int SW = DW / 8;
    localparam int IW = idx_w(N_MST);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    bcnt_t           bcnt_q, bcnt_d;

    logic [N_MST-1:0] req;
    logic [N_MST-1:0] pk_gnt;
    logic [IW-1:0]    pk_idx;
    logic             pk_any;
    logic [N_MST-1:0] owner_oh;
    logic             other_req;
    logic [IW-1:0]    sel_idx;
    logic             sel_vld;
    logic             tmo;

    assign req       = m_stb_i & m_cyc_i;
    assign owner_oh  = N_MST'(1) << owner_q;
    assign other_req = |(req & ~owner_oh);

    wb_rr_picker #(
        .N  (N_MST),
        .IW (IW)
    ) u_picker (
        .req  (req),
        .last (last_q),
        .gnt  (pk_gnt),
        .idx  (pk_idx),
        .any  (pk_any)
    );

`ifdef WB_ARB_TIMEOUT_EN
    wdog_t wdog_q, wdog_d;

    // count owner strobe cycles left unacked; fire once at the limit
    always_comb begin
        wdog_d = wdog_q;
        tmo    = 1'b0;
        if (state_q == IDLE || s_ack_i || !m_cyc_i[owner_q]) begin
            wdog_d = '0;
        end else if (m_stb_i[owner_q]) begin
            if (wdog_q == wdog_t'(TIMEOUT - 1)) begin
                tmo    = 1'b1;
                wdog_d = '0;
            end else begin
                wdog_d = wdog_q + wdog_t'(1);
            end
        end
    end

    // watchdog register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // ownership FSM: zero-latency grant in IDLE, burst-limited hold in BUSY
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        sel_idx = owner_q;
        sel_vld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pk_any) begin
                    sel_idx = pk_idx;
                    sel_vld = 1'b1;
                    state_d = BUSY;
                    owner_d = pk_idx;
                    last_d  = pk_idx;
                    bcnt_d  = s_ack_i ? bcnt_t'(1) : '0;
                end
            end
            BUSY: begin
                sel_vld = 1'b1;
                if (!m_cyc_i[owner_q] || tmo) begin
                    state_d = IDLE;
                end else if (s_ack_i) begin
                    if (bcnt_q + bcnt_t'(1) >= bcnt_t'(MAX_BURST)) begin
                        bcnt_d = '0;
                        if (other_req) begin
                            state_d = IDLE;
                        end
                    end else begin
                        bcnt_d = bcnt_q + bcnt_t'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; master 0 wins first after reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_MST - 1);
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // bus muxes; reset forces every output low at once
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_dat_o = '0;
        s_adr_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        gnt_o   = '0;
        if (!wb_rst_i) begin
            m_dat_o = s_dat_i;
            if (sel_vld) begin
                s_cyc_o = m_cyc_i[sel_idx];
                s_stb_o = m_stb_i[sel_idx];
                s_we_o  = m_we_i[sel_idx];
                s_sel_o = m_sel_i[sel_idx*SW +: SW];
                s_dat_o = m_dat_i[sel_idx*DW +: DW];
                s_adr_o = m_adr_i[sel_idx*AW +: AW];
                m_ack_o[sel_idx] = s_ack_i;
                gnt_o   = (state_q == IDLE) ? pk_gnt : owner_oh;
                m_err_o = tmo ? owner_oh : '0;
            end
        end
    end

endmodule
